score_counter: RTL
==================

// Module: score_counter
// PURPOSE
// - Score producer for the goose-run VGA game: accumulates score while a run is active and drives the 32-bit binary score consumed by the on-screen score renderer.
// - Counts in BCD internally (4 digits, no divider needed), also exposes the packed digits and a high-score register.
// - Sits between game control (start / game-over / bonus events, per-frame tick) and the display path.
// PARAMETERS
// - TICKS_PER_POINT  6     frame ticks per +1 point while running (1..63)
// - BONUS_POINTS     10    points added per bonus pulse (0..99)
// - MAX_SCORE        9999  saturation value (4 decimal digits)
// PORTS
// - clk        in   1   system clock (pixel clock domain)
// - rst_n      in   1   asynchronous reset, active-low
// - tick       in   1   one-cycle pulse per video frame
// - start      in   1   one-cycle pulse: begin new run (clears score)
// - game_over  in   1   one-cycle pulse: end current run
// - pause      in   1   level: hold scoring while high
// - bonus      in   1   one-cycle pulse: add BONUS_POINTS
// - score      out  32  binary score, zero-extended, 0..MAX_SCORE
// - score_bcd  out  16  {thou,hund,ten,unit} BCD digits of score
// - hi_bcd     out  16  BCD high score since reset
// - running    out  1   high in RUN state
// - new_hi     out  1   one-cycle pulse when hi_bcd updated at game over
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, score=0, score_bcd=0, hi_bcd=0, running=0, new_hi=0, tick prescaler=0.
// - FSM: IDLE --start--> RUN; RUN --game_over--> OVER; OVER --start--> RUN; start in RUN restarts (clears score, stays RUN).
// - start always clears score_bcd and prescaler in the same edge; start has priority over every other input.
// - RUN, pause=0: tick increments prescaler; when prescaler reaches TICKS_PER_POINT-1 and tick=1, prescaler->0 and score+1.
// - RUN, pause=1: prescaler and score frozen; bonus still ignored while paused.
// - bonus in RUN (pause=0): add BONUS_POINTS; if coincident with a +1 point, both apply (total BONUS_POINTS+1) same edge.
// - BCD add: per-digit add with decimal carry (digit>9 -> digit-10, carry 1); result > MAX_SCORE saturates to 9999; once 9999 no wrap.
// - game_over in RUN: next state OVER; score frozen; if score_bcd > hi_bcd, hi_bcd<=score_bcd and new_hi=1 for exactly one cycle after the edge.
// - game_over and bonus/tick same cycle: scoring increment applied first, compared value includes it.
// - game_over/tick/bonus in IDLE or OVER: ignored; score holds last run value in OVER.
// - score = thou*1000+hund*100+ten*10+unit, registered together with score_bcd (same cycle, latency 1 clk from triggering event).
// - running is a registered decode of state (high in RUN only).
// - Reset mid-run returns to IDLE immediately; hi_bcd lost (not retained).
// STRUCTURE
// - Shared package/header: FSM state encodings (IDLE/RUN/OVER), MAX_SCORE digit constants, BCD digit width.
// - One sub-module: bcd_adder4 (combinational 4-digit BCD add with saturation flag), instantiated once for score update.
// - Binary conversion via shift-add constants (x1000 = <<10 - <<4 - <<3, etc.), no dividers.
// TESTING
// - Reset then start, 6 ticks, pause=0 -> score=1, score_bcd=16'h0001 one clk after 6th tick.
// - Run to 0009, one more point -> score_bcd=16'h0010, score=10 (decimal carry ripple incl. 0999->1000).
// - score=9995, bonus (10) -> score=9999, further ticks/bonus keep 9999.
// - pause=1 for 20 ticks -> score and prescaler unchanged; release resumes from same prescaler count.
// - Run to 42, game_over -> OVER, hi_bcd=16'h0042, new_hi pulses 1 cycle; next run 30 + game_over -> hi stays 0042, no new_hi.
// - Bonus coincident with 6th tick -> +11; rst_n low mid-run -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/score_counter_pkg.sv
// Shared definitions for the goose-run score counter: FSM states, BCD digit
// constants and the BCD-to-binary / integer-to-BCD helpers.
package score_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int          DIGIT_W       = 4;
  localparam logic [3:0]  DIGIT_MAX     = 4'd9;
  localparam logic [15:0] MAX_SCORE_BCD = 16'h9999;

  // Shift-add weights: x1000 = <<10 - <<4 - <<3, x100 = <<6 + <<5 + <<2, x10 = <<3 + <<1.
  function automatic logic [31:0] bcd_to_bin(input logic [15:0] bcd);
    logic [31:0] thou, hund, ten, unit;
    thou = {28'd0, bcd[15:12]};
    hund = {28'd0, bcd[11:8]};
    ten  = {28'd0, bcd[7:4]};
    unit = {28'd0, bcd[3:0]};
    return (thou << 10) - (thou << 4) - (thou << 3)
         + (hund << 6) + (hund << 5) + (hund << 2)
         + (ten << 3) + (ten << 1) + unit;
  endfunction

  // Elaboration-time only: converts parameter values into BCD constants.
  function automatic logic [15:0] int_to_bcd(input int value);
    return {4'((value / 1000) % 10), 4'((value / 100) % 10),
            4'((value / 10) % 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/score_counter_bcd_adder4.sv
// Combinational 4-digit BCD adder; flags results that overflow four digits
// or exceed the saturation limit so the caller can clamp.
module bcd_adder4
  import score_counter_pkg::*;
#(
  parameter logic [15:0] MAX_BCD = MAX_SCORE_BCD
) (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        sat
);

  logic [15:0] raw_s;
  logic        carry_s;

  // Ripple decimal carry digit by digit; +6 on a 4-bit digit equals -10 mod 16.
  always_comb begin
    logic [4:0] dsum;
    raw_s   = 16'h0000;
    carry_s = 1'b0;
    dsum    = 5'd0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, a[i*DIGIT_W +: DIGIT_W]} + {1'b0, b[i*DIGIT_W +: DIGIT_W]} + {4'd0, carry_s};
      if (dsum > {1'b0, DIGIT_MAX}) begin
        raw_s[i*DIGIT_W +: DIGIT_W] = dsum[3:0] + 4'd6;
        carry_s                     = 1'b1;
      end else begin
        raw_s[i*DIGIT_W +: DIGIT_W] = dsum[3:0];
        carry_s                     = 1'b0;
      end
    end
    sat = carry_s || (raw_s > MAX_BCD);
    sum = raw_s;
  end

endmodule

// File: rtl/score_counter.sv
// Goose-run score counter: BCD score accumulation per frame tick and bonus,
// saturating at MAX_SCORE, with high-score capture at game over.
module score_counter
  import score_counter_pkg::*;
#(
  parameter int TICKS_PER_POINT = 6,
  parameter int BONUS_POINTS    = 10,
  parameter int MAX_SCORE       = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic        game_over,
  input  logic        pause,
  input  logic        bonus,
  output logic [31:0] score,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd,
  output logic        running,
  output logic        new_hi
);

  localparam logic [5:0]  PRESC_LAST = 6'(TICKS_PER_POINT - 1);
  localparam logic [15:0] BONUS_BCD  = int_to_bcd(BONUS_POINTS);
  localparam logic [15:0] BONUS1_BCD = int_to_bcd(BONUS_POINTS + 1);
  localparam logic [15:0] MAX_BCD    = int_to_bcd(MAX_SCORE);

  state_t      state_r;
  logic [5:0]  presc_r;
  logic [15:0] score_bcd_r;
  logic [15:0] hi_bcd_r;
  logic [31:0] score_r;
  logic        running_r;
  logic        new_hi_r;

  logic        point_s;
  logic        bonus_hit_s;
  logic [15:0] addend_s;
  logic [15:0] sum_s;
  logic        sat_s;
  logic [15:0] next_bcd_s;

  // Scoring events only count while running and not paused.
  always_comb begin
    point_s     = 1'b0;
    bonus_hit_s = 1'b0;
    if ((state_r == ST_RUN) && !pause) begin
      point_s     = tick && (presc_r == PRESC_LAST);
      bonus_hit_s = bonus;
    end else begin
      point_s     = 1'b0;
      bonus_hit_s = 1'b0;
    end
    case ({bonus_hit_s, point_s})
      2'b01:   addend_s = 16'h0001;
      2'b10:   addend_s = BONUS_BCD;
      2'b11:   addend_s = BONUS1_BCD;
      default: addend_s = 16'h0000;
    endcase
  end

  bcd_adder4 #(.MAX_BCD(MAX_BCD)) u_adder (
    .a   (score_bcd_r),
    .b   (addend_s),
    .sum (sum_s),
    .sat (sat_s)
  );

  assign next_bcd_s = sat_s ? MAX_BCD : sum_s;

  // Run-state FSM with registered score, high score and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      presc_r     <= 6'd0;
      score_bcd_r <= 16'h0000;
      hi_bcd_r    <= 16'h0000;
      score_r     <= 32'd0;
      running_r   <= 1'b0;
      new_hi_r    <= 1'b0;
    end else begin
      new_hi_r <= 1'b0;
      if (start) begin
        state_r     <= ST_RUN;
        running_r   <= 1'b1;
        presc_r     <= 6'd0;
        score_bcd_r <= 16'h0000;
        score_r     <= 32'd0;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (!pause && tick) begin
              presc_r <= (presc_r == PRESC_LAST) ? 6'd0 : presc_r + 6'd1;
            end
            score_bcd_r <= next_bcd_s;
            score_r     <= bcd_to_bin(next_bcd_s);
            // BCD ordering matches numeric ordering, so a plain compare works.
            if (game_over) begin
              state_r   <= ST_OVER;
              running_r <= 1'b0;
              if (next_bcd_s > hi_bcd_r) begin
                hi_bcd_r <= next_bcd_s;
                new_hi_r <= 1'b1;
              end
            end
          end
          ST_IDLE, ST_OVER: begin
            state_r <= state_r;
          end
          default: begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign score     = score_r;
  assign score_bcd = score_bcd_r;
  assign hi_bcd    = hi_bcd_r;
  assign running   = running_r;
  assign new_hi    = new_hi_r;

endmodule
